countdown_timer: RTL and testbench

Loadable 5-bit down-counter with terminal-count signalling, the decrementing counterpart to the CPU's loadable up-counter. It holds a reload value, counts it down to zero on qualified ticks, and reports expiry through a one-cycle terminal-count pulse and a sticky `done` flag. It sits beside the up-counter in the CPU datapath and serves loop counts, wait states and periodic ticks. Two modes are supported: one-shot, and auto-reload for periodic operation.

---
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 73 +++++++
 tb/tb_countdown_timer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: reload value and strobes in,
// count and expiry status out.
interface countdown_timer_if #(parameter int WIDTH = 5);
   logic [WIDTH-1:0] data;
   logic             load;
   logic             start;
   logic             enable;
   logic             reload_mode;
   logic             ack;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output data, load, start, enable, reload_mode, ack,
      input  count, busy, tc, done
   );

   modport slave (
      input  data, load, start, enable, reload_mode, ack,
      output count, busy, tc, done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, a registered
// terminal-count pulse and a sticky done flag.
module countdown_timer #(
   parameter int WIDTH = 5
) (
   input logic             clk,
   input logic             rst_,
   countdown_timer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // Strobe priority: load > start > ack > enable.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (bus.load) begin
         reload_d = bus.data;
         count_d  = bus.data;
         state_d  = IDLE;
      end else if (bus.start && (state_q != RUN)) begin
         count_d = reload_q;
         if (reload_q != '0) begin
            state_d = RUN;
         end else begin
            state_d = DONE;
            tc_d    = 1'b1;
         end
      end else if (bus.ack && (state_q == DONE)) begin
         state_d = IDLE;
      end else if (bus.enable && (state_q == RUN)) begin
         // Terminal is detected at 1 so the decrement can never wrap.
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            tc_d = 1'b1;
            if (bus.reload_mode) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = DONE;
            end
         end
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);
   assign bus.tc    = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a behavioural
// model kept in the bench.
module tb_countdown_timer;

   localparam int WIDTH = 5;

   logic clk;
   logic rst_;
   int   checks;
   int   errors;

   countdown_timer_if #(.WIDTH(WIDTH)) cif ();

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (cif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: count value, reload value and three status bits.
   int m_count;
   int m_reload;
   bit m_busy;
   bit m_done;
   bit m_tc;

   task automatic model_reset();
      m_count  = 0;
      m_reload = 0;
      m_busy   = 0;
      m_done   = 0;
      m_tc     = 0;
   endtask

   task automatic model_edge();
      if (cif.load) begin
         m_reload = int'(cif.data);
         m_count  = int'(cif.data);
         m_busy   = 0;
         m_done   = 0;
         m_tc     = 0;
      end else if (cif.start && !m_busy) begin
         m_count = m_reload;
         m_busy  = (m_reload != 0);
         m_done  = (m_reload == 0);
         m_tc    = (m_reload == 0);
      end else if (cif.ack && m_done) begin
         m_done = 0;
         m_tc   = 0;
      end else if (cif.enable && m_busy) begin
         if (m_count == 1) begin
            m_tc = 1;
            if (cif.reload_mode) begin
               m_count = m_reload;
            end else begin
               m_count = 0;
               m_busy  = 0;
               m_done  = 1;
            end
         end else begin
            m_count = m_count - 1;
            m_tc    = 0;
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".count"}, 32'(cif.count), 32'(m_count));
      chk({tag, ".busy"},  32'(cif.busy),  32'(m_busy));
      chk({tag, ".tc"},    32'(cif.tc),    32'(m_tc));
      chk({tag, ".done"},  32'(cif.done),  32'(m_done));
   endtask

   // One clock: inputs are already set; sample 1 time unit after the edge.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      chk_model(tag);
   endtask

   task automatic clear_inputs();
      cif.load   = 0;
      cif.start  = 0;
      cif.enable = 0;
      cif.ack    = 0;
   endtask

   initial begin
      int tc_seen;
      int first_tc;
      int last_tc;
      int done_seen;
      int ticks;

      checks = 0;
      errors = 0;
      rst_   = 0;
      cif.data = '0;
      cif.reload_mode = 0;
      clear_inputs();
      model_reset();
      #12;
      chk_model("reset");
      rst_ = 1;

      // One-shot from 3.
      cif.load = 1; cif.data = 5'd3;
      tick("os_load");
      chk("os_load_count", 32'(cif.count), 32'd3);
      cif.load = 0; cif.start = 1;
      tick("os_start");
      chk("os_start_busy", 32'(cif.busy), 32'd1);
      cif.start = 0; cif.enable = 1;
      tick("os_t1");
      chk("os_t1_count", 32'(cif.count), 32'd2);
      tick("os_t2");
      chk("os_t2_count", 32'(cif.count), 32'd1);
      tick("os_t3");
      chk("os_t3_count", 32'(cif.count), 32'd0);
      chk("os_t3_tc",    32'(cif.tc),    32'd1);
      chk("os_t3_done",  32'(cif.done),  32'd1);
      chk("os_t3_busy",  32'(cif.busy),  32'd0);
      tick("os_after");
      chk("os_after_tc",   32'(cif.tc),   32'd0);
      chk("os_after_done", 32'(cif.done), 32'd1);
      cif.enable = 0; cif.ack = 1;
      tick("os_ack");
      chk("os_ack_done", 32'(cif.done), 32'd0);
      cif.ack = 0;

      // Auto-reload from 4 for 12 enabled cycles.
      cif.load = 1; cif.data = 5'd4; cif.reload_mode = 1;
      tick("ar_load");
      cif.load = 0; cif.start = 1;
      tick("ar_start");
      cif.start = 0; cif.enable = 1;
      tc_seen = 0; first_tc = -1; last_tc = -1; done_seen = 0;
      for (int i = 1; i <= 12; i++) begin
         tick("ar_run");
         if (cif.tc === 1'b1) begin
            tc_seen++;
            if (first_tc < 0) first_tc = i;
            last_tc = i;
         end
         if (cif.done !== 1'b0) done_seen++;
      end
      chk("ar_tc_pulses", 32'(tc_seen), 32'd3);
      chk("ar_tc_first",  32'(first_tc), 32'd4);
      chk("ar_tc_span",   32'(last_tc - first_tc), 32'd8);
      chk("ar_done_seen", 32'(done_seen), 32'd0);
      chk("ar_busy",      32'(cif.busy), 32'd1);
      cif.enable = 0; cif.reload_mode = 0;

      // Gapped enable from 2: pattern 1,0,0,1.
      cif.load = 1; cif.data = 5'd2;
      tick("gap_load");
      cif.load = 0; cif.start = 1;
      tick("gap_start");
      cif.start = 0;
      cif.enable = 1; tick("gap_e1");
      chk("gap_e1_count", 32'(cif.count), 32'd1);
      cif.enable = 0; tick("gap_e0a");
      cif.enable = 0; tick("gap_e0b");
      chk("gap_e0_count", 32'(cif.count), 32'd1);
      chk("gap_e0_tc",    32'(cif.tc),    32'd0);
      cif.enable = 1; tick("gap_e2");
      chk("gap_e2_count", 32'(cif.count), 32'd0);
      chk("gap_e2_tc",    32'(cif.tc),    32'd1);
      cif.enable = 0;

      // load together with start during RUN.
      cif.load = 1; cif.data = 5'd7;
      tick("pri_load7");
      cif.load = 0; cif.start = 1;
      tick("pri_start");
      cif.start = 0; cif.enable = 1;
      tick("pri_run");
      cif.enable = 0; cif.load = 1; cif.start = 1; cif.data = 5'd5;
      tick("pri_ld_st");
      chk("pri_ld_st_busy",  32'(cif.busy),  32'd0);
      chk("pri_ld_st_count", 32'(cif.count), 32'd5);
      clear_inputs();

      // start together with ack in DONE, then start during RUN.
      cif.load = 1; cif.data = 5'd2;
      tick("pri_load2");
      cif.load = 0; cif.start = 1;
      tick("pri_start2");
      cif.start = 0; cif.enable = 1;
      tick("pri_d1");
      tick("pri_d2");
      chk("pri_done", 32'(cif.done), 32'd1);
      cif.enable = 0; cif.start = 1; cif.ack = 1;
      tick("pri_st_ack");
      chk("pri_st_ack_busy",  32'(cif.busy),  32'd1);
      chk("pri_st_ack_count", 32'(cif.count), 32'd2);
      cif.ack = 0; cif.enable = 1; cif.start = 0;
      tick("pri_dec");
      cif.enable = 0; cif.start = 1;
      tick("pri_st_run");
      chk("pri_st_run_count", 32'(cif.count), 32'd1);
      chk("pri_st_run_busy",  32'(cif.busy),  32'd1);
      clear_inputs();

      // Zero reload.
      cif.load = 1; cif.data = 5'd0;
      tick("zero_load");
      cif.load = 0; cif.start = 1;
      tick("zero_start");
      chk("zero_tc",   32'(cif.tc),   32'd1);
      chk("zero_done", 32'(cif.done), 32'd1);
      chk("zero_busy", 32'(cif.busy), 32'd0);
      cif.start = 0;
      tick("zero_after");
      chk("zero_after_busy", 32'(cif.busy), 32'd0);

      // All-ones reload, one-shot: 31 ticks, bounded wait.
      cif.load = 1; cif.data = 5'd31;
      tick("max_load");
      cif.load = 0; cif.start = 1;
      tick("max_start");
      cif.start = 0; cif.enable = 1;
      ticks = 0;
      while (cif.done !== 1'b1 && ticks < 40) begin
         tick("max_run");
         ticks++;
      end
      chk("max_ticks", 32'(ticks), 32'd31);
      chk("max_count", 32'(cif.count), 32'd0);
      clear_inputs();

      // Randomized traffic; start only on cycles without enable.
      for (int i = 0; i < 400; i++) begin
         cif.load        = ($urandom_range(0, 19) == 0);
         cif.start       = ($urandom_range(0, 9) == 0);
         cif.ack         = ($urandom_range(0, 5) == 0);
         cif.enable      = cif.start ? 1'b0 : ($urandom_range(0, 9) < 7);
         cif.reload_mode = ($urandom_range(0, 3) == 0);
         cif.data        = WIDTH'($urandom_range(0, 9));
         tick("rand");
      end
      clear_inputs();
      cif.reload_mode = 0;

      // Asynchronous reset mid-run at count 2.
      cif.load = 1; cif.data = 5'd3;
      tick("rst_load");
      cif.load = 0; cif.start = 1;
      tick("rst_start");
      cif.start = 0; cif.enable = 1;
      tick("rst_t1");
      chk("rst_pre_count", 32'(cif.count), 32'd2);
      #2;
      rst_ = 0;
      #1;
      model_reset();
      chk_model("rst_async");
      chk("rst_async_count", 32'(cif.count), 32'd0);
      #3;
      rst_ = 1;
      cif.enable = 0;
      tick("rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
